alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq_muldiv.sv | 105 ++++++++++
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag positions for alu_seq
// Purpose: common definitions imported by every alu_seq file.
// Contents: opcode constants OP_ADD..OP_DIV, state_t FSM enum,
//           FLAG_* bit positions of the packed {N,Z,C,V} flag vector,
//           is_iter() which marks the opcodes that use the iterative datapath.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_EXEC,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result bus between control unit and alu_seq
// Purpose: bundles the start/opcode/operand request and the result/status response.
// Signals: start, s[3:0], inbus[WIDTH-1:0]           (control unit -> ALU)
//          outbus[WIDTH-1:0], finish, busy,
//          negative, zero, carry, overflow           (ALU -> control unit)
// Modports: master = control unit side, slave = ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic [3:0]       s;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             finish;
    logic             busy;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output start, s, inbus,
        input  outbus, finish, busy, negative, zero, carry, overflow
    );

    modport slave (
        input  start, s, inbus,
        output outbus, finish, busy, negative, zero, carry, overflow
    );

endinterface

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative unsigned shift-add multiplier / restoring divider
// Purpose: one bit per cycle over WIDTH cycles, sharing one accumulator and one shift register.
// Ports: clk, rst       clock, synchronous active-high reset
//        start_i        load operands and begin (one-cycle pulse)
//        is_div_i       1 = divide, 0 = multiply (latched with start_i)
//        a_i, b_i       multiplicand/dividend, multiplier/divisor
//        done_o         one-cycle strobe in the cycle after the last iteration
//        lo_o, hi_o     product low/high word, or quotient/remainder
module alu_seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // acc: product high word / partial remainder; sr: multiplier shifting out
    // while product low bits shift in, or dividend shifting out while
    // quotient bits shift in.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q, sr_q[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        // When rem_ge holds the true difference is below the divisor, so the
        // top bit is always zero and a WIDTH-bit subtract is exact.
        rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

        acc_d    = acc_q;
        sr_d     = sr_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (start_i) begin
            acc_d    = '0;
            sr_d     = a_i;
            opnd_d   = b_i;
            cnt_d    = '0;
            div_d    = is_div_i;
            active_d = 1'b1;
        end else if (active_q) begin
            if (div_q) begin
                acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], rem_ge};
            end else begin
                acc_d = mul_sum[WIDTH:1];
                sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sr_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done_o = done_q;
    assign lo_o   = sr_q;
    assign hi_o   = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle sequential ALU with iterative multiply/divide
// Purpose: accepts opcode + operand A on start, operand B next cycle, returns
//          one result word (two for MUL/DIV) with finish and status flags.
// Ports: clk   rising-edge clock
//        rst   synchronous, active-high reset
//        bus   alu_seq_if slave: start, s, inbus in; outbus, finish, busy,
//              negative, zero, carry, overflow out
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] outbus_q, outbus_d;
    logic             finish_q, finish_d;
    logic [3:0]       flags_q, flags_d;

    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [3:0]       res_flags;

    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic [WIDTH:0]        shl_ext;
    logic signed [WIDTH:0] shr_ext;
    logic [CNT_W-2:0]      sh_amt;
    logic                  sh_sat;
    logic                  sh_exact;
    logic                  car;
    logic                  ovf;
    logic                  nz_valid;

    // Operands go to the iterative unit on the B-capture edge so that its
    // WIDTH iterations start on the first EXEC edge.
    assign md_start = (state_q == S_LOAD_B) && is_iter(op_q);

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .is_div_i (op_q == OP_DIV),
        .a_i      (a_q),
        .b_i      (bus.inbus),
        .done_o   (md_done),
        .lo_o     (md_lo),
        .hi_o     (md_hi)
    );

    // Result words and flags for whichever opcode is latched.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        sh_amt   = b_q[CNT_W-2:0];
        sh_sat   = (b_q >= W_VAL);
        sh_exact = (b_q == W_VAL);
        // Extra bit beyond the word catches the last bit shifted out.
        shl_ext  = {1'b0, a_q} << sh_amt;
        shr_ext  = $signed({a_q, 1'b0}) >>> sh_amt;

        res_lo    = '0;
        res_hi    = '0;
        res_flags = '0;
        car       = 1'b0;
        ovf       = 1'b0;
        nz_valid  = 1'b1;

        case (op_q)
            OP_ADD: begin
                res_lo = sum[WIDTH-1:0];
                car    = sum[WIDTH];
                ovf    = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_lo = diff[WIDTH-1:0];
                car    = diff[WIDTH];
                ovf    = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND: res_lo = a_q & b_q;
            OP_OR:  res_lo = a_q | b_q;
            OP_XOR: res_lo = a_q ^ b_q;
            OP_SHL: begin
                if (sh_sat) begin
                    res_lo = '0;
                    car    = sh_exact ? a_q[0] : 1'b0;
                end else begin
                    res_lo = shl_ext[WIDTH-1:0];
                    car    = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (sh_sat) begin
                    res_lo = {WIDTH{a_q[MSB]}};
                    car    = a_q[MSB];
                end else begin
                    res_lo = shr_ext[WIDTH:1];
                    car    = shr_ext[0];
                end
            end
            OP_MUL: begin
                res_lo = md_lo;
                res_hi = md_hi;
                car    = |md_hi;
                ovf    = |md_hi;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                    ovf    = 1'b1;
                end else begin
                    res_lo = md_lo;
                    res_hi = md_hi;
                end
            end
            default: nz_valid = 1'b0;
        endcase

        res_flags[FLAG_C] = car;
        res_flags[FLAG_V] = ovf;
        if (nz_valid) begin
            if (op_q == OP_MUL) begin
                res_flags[FLAG_N] = res_hi[MSB];
                res_flags[FLAG_Z] = ({res_hi, res_lo} == '0);
            end else begin
                res_flags[FLAG_N] = res_lo[MSB];
                res_flags[FLAG_Z] = (res_lo == '0);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   if (!is_iter(op_q) || md_done) state_d = S_OUT_LO;
            S_OUT_LO: state_d = is_iter(op_q) ? S_OUT_HI : S_IDLE;
            S_OUT_HI: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand latches and registered outputs; outbus returns to zero
    // whenever finish is low.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        flags_d  = flags_q;
        outbus_d = '0;
        finish_d = 1'b0;

        if (state_q == S_IDLE && bus.start) begin
            op_d    = bus.s;
            a_d     = bus.inbus;
            flags_d = '0;
        end
        if (state_q == S_LOAD_B) begin
            b_d = bus.inbus;
        end
        if (state_q == S_EXEC && state_d == S_OUT_LO) begin
            outbus_d = res_lo;
            finish_d = 1'b1;
            flags_d  = res_flags;
        end
        if (state_q == S_OUT_LO && state_d == S_OUT_HI) begin
            outbus_d = res_hi;
            finish_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            outbus_q <= '0;
            finish_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            outbus_q <= outbus_d;
            finish_q <= finish_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.outbus   = outbus_q;
    assign bus.finish   = finish_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.negative = flags_q[FLAG_N];
    assign bus.zero     = flags_q[FLAG_Z];
    assign bus.carry    = flags_q[FLAG_C];
    assign bus.overflow = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=16 and WIDTH=8
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(16)) i16 ();
    alu_seq_if #(.WIDTH(8))  i8 ();

    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));

    typedef struct {
        string       tag;
        logic [15:0] val;
        logic [3:0]  flg;
        logic [3:0]  msk;
        int          at;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] outw(input bit sel);
        return sel ? {8'h00, i8.outbus} : i16.outbus;
    endfunction

    function automatic logic [3:0] flgs(input bit sel);
        return sel ? {i8.negative, i8.zero, i8.carry, i8.overflow}
                   : {i16.negative, i16.zero, i16.carry, i16.overflow};
    endfunction

    function automatic logic busyw(input bit sel);
        return sel ? i8.busy : i16.busy;
    endfunction

    function automatic logic finw(input bit sel);
        return sel ? i8.finish : i16.finish;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [3:0] op, input logic [15:0] v);
        if (sel) begin
            i8.start = st; i8.s = op; i8.inbus = v[7:0];
        end else begin
            i16.start = st; i16.s = op; i16.inbus = v;
        end
    endtask

    task automatic push(input bit sel, input string tag, input logic [15:0] val,
                        input logic [3:0] flg, input logic [3:0] msk, input int at);
        exp_t e;
        e.tag = tag; e.val = val; e.flg = flg; e.msk = msk; e.at = at;
        if (sel) q8.push_back(e); else q16.push_back(e);
    endtask

    // Scoreboard side: every finish cycle must match the oldest expectation.
    task automatic mon(input bit sel);
        exp_t e;
        int   n;
        n = sel ? q8.size() : q16.size();
        if (finw(sel) === 1'b1) begin
            chk(sel ? "w8/finish_expected" : "w16/finish_expected", (n != 0), 1);
            if (n != 0) begin
                e = sel ? q8.pop_front() : q16.pop_front();
                chk({e.tag, "/outbus"}, outw(sel), e.val);
                chk({e.tag, "/flags"}, flgs(sel) & e.msk, e.flg & e.msk);
                chk({e.tag, "/cycle"}, cyc, e.at);
            end
        end else begin
            chk(sel ? "w8/idle_outbus" : "w16/idle_outbus", outw(sel), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    // One full operation; call on a falling edge with the DUT idle.
    task automatic run(input bit sel, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] lo, input logic [15:0] hi,
                       input logic [3:0] flg, input logic [3:0] msk, input string tag);
        int c;
        int w;
        int last;
        w = sel ? 8 : 16;
        c = cyc;
        drive(sel, 1'b1, op, a);
        @(negedge clk);
        chk({tag, "/busy_after_start"}, busyw(sel), 1);
        drive(sel, 1'b0, op, b);
        if (op == 4'd7 || op == 4'd8) begin
            push(sel, {tag, "/lo"}, lo, flg, msk, c + 3 + w);
            push(sel, {tag, "/hi"}, hi, flg, msk, c + 4 + w);
            last = c + 4 + w;
        end else begin
            push(sel, tag, lo, flg, msk, c + 3);
            last = c + 3;
        end
        while (cyc < last) @(negedge clk);
        @(negedge clk);
        chk({tag, "/busy_after_finish"}, busyw(sel), 0);
        chk({tag, "/all_results_seen"}, sel ? q8.size() : q16.size(), 0);
        if (sel) q8.delete(); else q16.delete();
    endtask

    initial begin
        int c;
        drive(1'b0, 1'b0, 4'd0, 16'h0000);
        drive(1'b1, 1'b0, 4'd0, 16'h0000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset/outbus", outw(k[0]), 0);
            chk("reset/finish", finw(k[0]), 0);
            chk("reset/busy", busyw(k[0]), 0);
            chk("reset/flags", flgs(k[0]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        //    sel op     A         B         lo        hi        NZCV     mask
        run(0, 4'd0, 16'd5,    16'd2147, 16'd2152, 16'h0000, 4'b0000, 4'hF, "add");
        run(0, 4'd1, 16'd5,    16'd2147, 16'hF7A2, 16'h0000, 4'b1010, 4'hF, "sub");
        run(0, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1001, 4'hF, "add_ovf");
        run(0, 4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 4'hF, "and");
        run(0, 4'd3, 16'h8000, 16'h0001, 16'h8001, 16'h0000, 4'b1000, 4'hF, "or");
        run(0, 4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100, 4'hF, "xor_zero");
        run(0, 4'd5, 16'h8001, 16'd1,    16'h0002, 16'h0000, 4'b0010, 4'hF, "shl1");
        run(0, 4'd5, 16'h1234, 16'd0,    16'h1234, 16'h0000, 4'b0000, 4'hF, "shl0");
        run(0, 4'd6, 16'h8000, 16'd4,    16'hF800, 16'h0000, 4'b1000, 4'hF, "shr4");
        run(0, 4'd6, 16'h0009, 16'd1,    16'h0004, 16'h0000, 4'b0010, 4'hF, "shr1");
        run(0, 4'd6, 16'h8000, 16'd16,   16'hFFFF, 16'h0000, 4'b1010, 4'hF, "shr_sat");
        run(0, 4'd7, 16'd300,  16'd300,  16'h5F90, 16'h0001, 4'b0011, 4'hF, "mul");
        run(0, 4'd8, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 4'hF, "div");
        run(0, 4'd8, 16'd100,  16'd0,    16'hFFFF, 16'd100,  4'b0001, 4'b0011, "div0");

        // start held during EXEC must not disturb a running divide
        c = cyc;
        drive(0, 1'b1, 4'd8, 16'd100);
        @(negedge clk);
        drive(0, 1'b0, 4'd8, 16'd7);
        push(0, "busy_start/lo", 16'd14, 4'b0000, 4'hF, c + 19);
        push(0, "busy_start/hi", 16'd2,  4'b0000, 4'hF, c + 20);
        while (cyc < c + 4) @(negedge clk);
        drive(0, 1'b1, 4'd0, 16'h0055);
        while (cyc < c + 12) @(negedge clk);
        drive(0, 1'b0, 4'd0, 16'h0000);
        while (cyc < c + 20) @(negedge clk);
        @(negedge clk);
        chk("busy_start/busy_after", busyw(0), 0);
        chk("busy_start/all_seen", q16.size(), 0);
        q16.delete();

        // reset in the fifth EXEC cycle of a multiply discards it
        c = cyc;
        drive(0, 1'b1, 4'd7, 16'd300);
        @(negedge clk);
        drive(0, 1'b0, 4'd7, 16'd300);
        while (cyc < c + 6) @(negedge clk);
        chk("rst_exec/busy_before", busyw(0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec/outbus", outw(0), 0);
        chk("rst_exec/finish", finw(0), 0);
        chk("rst_exec/busy", busyw(0), 0);
        chk("rst_exec/flags", flgs(0), 0);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        chk("rst_exec/stays_idle", busyw(0), 0);

        // reset wins over a simultaneous start
        rst = 1'b1;
        drive(0, 1'b1, 4'd0, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 4'd0, 16'd0);
        chk("rst_start/busy", busyw(0), 0);
        @(negedge clk);
        chk("rst_start/busy_later", busyw(0), 0);

        run(0, 4'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1011, 4'hF, "mul_max");

        run(1, 4'd0,  16'h00FF, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 4'hF, "w8_add_wrap");
        run(1, 4'd7,  16'h00FF, 16'h00FF, 16'h0001, 16'h00FE, 4'b1011, 4'hF, "w8_mul");
        run(1, 4'd5,  16'h0081, 16'd9,    16'h0000, 16'h0000, 4'b0100, 4'hF, "w8_shl9");
        run(1, 4'd12, 16'h005A, 16'h003C, 16'h0000, 16'h0000, 4'b0000, 4'hF, "w8_reserved");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
